// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and leading-zero blanking helper for bin_to_bcd.
package bcd_pkg;

  localparam int          BCD_DIGITS  = 5;
  localparam int          BCD_W       = 4 * BCD_DIGITS;
  localparam int unsigned BCD_MAX     = 99999;
  localparam logic [3:0]  DIGIT_BLANK = 4'hF;
  localparam int          MAG_W       = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } bcd_state_e;

  // Blank each leading zero digit from the top down to d1; d0 always shows.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] digits);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = digits;
    lead = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (lead && (r[4*i +: 4] == 4'h0)) begin
        r[4*i +: 4] = DIGIT_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// Start/result handshake bundle between a requester and the bin_to_bcd converter.
interface bin_to_bcd_if
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W = 18
);

  logic            start;
  logic [IN_W-1:0] bin_in;
  logic            busy;
  logic            done;
  logic [BCD_W:0]  bcd_out;
  logic            ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative signed binary to sign-magnitude BCD converter (shift-and-add-3).
// Define BIN_TO_BCD_LZB_EN to blank leading zero digits d4..d1 with 4'hF.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W = 18
) (
  input  logic        clk,
  input  logic        rst,
  bin_to_bcd_if.slave bus
);

  // Count value reserved for the result-registering step after the last shift.
  localparam logic [4:0] FIN_CNT = 5'(MAG_W);

  bcd_state_e             state_q, state_d;
  logic [IN_W-1:0]        bin_q;
  logic [IN_W-1:0]        abs_val;
  logic                   too_big;
  logic                   sign_q;
  logic                   ovf_pend_q;
  logic                   ovf_q;
  logic [MAG_W-1:0]       mag_q;
  logic [BCD_W-1:0]       acc_q;
  logic [BCD_W-1:0]       acc_corr;
  logic [BCD_W-1:0]       digits_fin;
  logic [BCD_W+MAG_W-1:0] shifted;
  logic [4:0]             cnt_q;
  logic [BCD_W:0]         bcd_q;

  // Full-width negate, so the most negative input stays positive and overflows.
  assign abs_val = bin_q[IN_W-1] ? (-bin_q) : bin_q;
  assign too_big = abs_val > IN_W'(BCD_MAX);

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit     (acc_q[4*g +: 4]),
      .corrected (acc_corr[4*g +: 4])
    );
  end

  assign shifted = {acc_corr, mag_q} << 1;

`ifdef BIN_TO_BCD_LZB_EN
  assign digits_fin = blank_leading(acc_q);
`else
  assign digits_fin = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = bus.start ? ST_LOAD : ST_IDLE;
      ST_LOAD:          state_d = ST_SHIFT;
      ST_SHIFT:         if (cnt_q == FIN_CNT) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) bin_q <= bus.bin_in;
        end
        ST_LOAD: begin
          sign_q     <= bin_q[IN_W-1];
          mag_q      <= abs_val[MAG_W-1:0];
          acc_q      <= '0;
          ovf_pend_q <= too_big;
          // Overflow skips the shifts and goes straight to the final step.
          cnt_q      <= too_big ? FIN_CNT : 5'd0;
        end
        ST_SHIFT: begin
          if (cnt_q == FIN_CNT) begin
            ovf_q <= ovf_pend_q;
            if (ovf_pend_q) begin
              bcd_q <= {sign_q, {BCD_DIGITS{DIGIT_BLANK}}};
            end else begin
              bcd_q <= {sign_q & (acc_q != '0), digits_fin};
            end
          end else begin
            acc_q <= shifted[BCD_W+MAG_W-1:MAG_W];
            mag_q <= shifted[MAG_W-1:0];
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed table-driven bench for bin_to_bcd, plus reset and back-to-back sequences.
module tb_bin_to_bcd;

  typedef struct {
    int          value;
    logic [20:0] exp_bcd;
    logic [20:0] exp_lzb;
    logic        exp_ovf;
    int          lat;
  } vec_t;

`ifdef BIN_TO_BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [20:0] last_bcd;
  vec_t vecs[13];

  bin_to_bcd_if #(.IN_W(18)) bus ();

  bin_to_bcd #(.IN_W(18)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; start is sampled at the next edge (E).
  task automatic convert(input int value, input logic [20:0] exp_bcd, input logic exp_ovf,
                         input int exp_lat, input string tag);
    int n;
    n = -1;
    bus.bin_in = 18'(value);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = ~bus.bin_in;
    check({tag, "_busy_early"}, 32'(bus.busy), 32'd1);
    check({tag, "_hold"}, 32'(bus.bcd_out), 32'(last_bcd));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    last_bcd = exp_bcd;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          n;
    int          extra;
    logic [20:0] exp42;
    logic [20:0] exp1;

    checks   = 0;
    errors   = 0;
    last_bcd = '0;

    //          value     plain      blanked    ovf  lat
    vecs[0]  = '{ 12345,  21'h012345, 21'h012345, 1'b0, 19};
    vecs[1]  = '{-12345,  21'h112345, 21'h112345, 1'b0, 19};
    vecs[2]  = '{ 99999,  21'h099999, 21'h099999, 1'b0, 19};
    vecs[3]  = '{-1,      21'h100001, 21'h1FFFF1, 1'b0, 19};
    vecs[4]  = '{ 100000, 21'h0FFFFF, 21'h0FFFFF, 1'b1, 2};
    vecs[5]  = '{-131072, 21'h1FFFFF, 21'h1FFFFF, 1'b1, 2};
    vecs[6]  = '{ 0,      21'h000000, 21'h0FFFF0, 1'b0, 19};
    vecs[7]  = '{ 1,      21'h000001, 21'h0FFFF1, 1'b0, 19};
    vecs[8]  = '{-99999,  21'h199999, 21'h199999, 1'b0, 19};
    vecs[9]  = '{ 5000,   21'h005000, 21'h0F5000, 1'b0, 19};
    vecs[10] = '{-100000, 21'h1FFFFF, 21'h1FFFFF, 1'b1, 2};
    vecs[11] = '{-100,    21'h100100, 21'h1FF100, 1'b0, 19};
    vecs[12] = '{ 80085,  21'h080085, 21'h080085, 1'b0, 19};

    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd_out), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Leave a nonzero result, then abort a conversion 10 cycles in.
    convert(-99999, 21'h199999, 1'b0, 19, "pre");
    bus.bin_in = 18'(99999);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_bcd", 32'(bus.bcd_out), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_busy_held", 32'(bus.busy), 32'd0);
    rst      = 1'b1;
    last_bcd = '0;
    @(posedge clk);
    #1;
    convert(12345, 21'h012345, 1'b0, 19, "postrst");

    for (int i = 0; i < 13; i++) begin
      convert(vecs[i].value, LZB ? vecs[i].exp_lzb : vecs[i].exp_bcd, vecs[i].exp_ovf,
              vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Back-to-back: 42, then 1 started during DONE, then 7 held while busy.
    exp42 = LZB ? 21'h0FFF42 : 21'h000042;
    exp1  = LZB ? 21'h0FFFF1 : 21'h000001;
    n = -1;
    bus.bin_in = 18'(42);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n = k;
        break;
      end
    end
    check("b2b_first_latency", 32'(n), 32'd19);
    check("b2b_first_bcd", 32'(bus.bcd_out), 32'(exp42));
    bus.bin_in = 18'(1);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.bin_in = 18'(7);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("b2b_hold", 32'(bus.bcd_out), 32'(exp42));
      if (k == 12) bus.start = 1'b0;
      if (bus.done) begin
        n = k;
        break;
      end
    end
    check("b2b_second_latency", 32'(n), 32'd19);
    check("b2b_second_bcd", 32'(bus.bcd_out), 32'(exp1));
    check("b2b_second_ovf", 32'(bus.ovf), 32'd0);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    check("b2b_no_third_done", 32'(extra), 32'd0);
    check("b2b_final_bcd", 32'(bus.bcd_out), 32'(exp1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
